xc_malu_issue: RTL and testbench

Initiator-side sequencer for the xc_malu multi-cycle arithmetic unit. It accepts one decoded instruction at a time from the execute stage and drives the malu request interface with operands held stable. It pulses flush on completion, captures the 64-bit result and returns it to register writeback as one or two 32-bit writes. It also implements pipeline kill, a hang watchdog and illegal-uop detection.

---
 rtl/xc_malu_issue_pkg.sv | 51 +++++
 rtl/xc_malu_issue.sv | 218 +++++++++++++++++++++
 tb/tb_xc_malu_issue.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/xc_malu_issue_pkg.sv
// ---------------------------------------------------------------------------
// xc_malu_issue_pkg
// Shared definitions for the xc_malu issue sequencer: uop and pack-width bit
// indices, field widths, FSM state encoding and a one-hot helper.
// ---------------------------------------------------------------------------
package xc_malu_issue_pkg;

  localparam int UOP_W = 14;
  localparam int PW_W  = 5;

  // uop one-hot bit positions (same order on req_uop and malu_uop)
  localparam int UOP_DIV    = 0;
  localparam int UOP_DIVU   = 1;
  localparam int UOP_REM    = 2;
  localparam int UOP_REMU   = 3;
  localparam int UOP_MUL    = 4;
  localparam int UOP_MULU   = 5;
  localparam int UOP_MULSU  = 6;
  localparam int UOP_CLMUL  = 7;
  localparam int UOP_PMUL   = 8;
  localparam int UOP_PCLMUL = 9;
  localparam int UOP_MADD   = 10;
  localparam int UOP_MSUB   = 11;
  localparam int UOP_MACC   = 12;
  localparam int UOP_MMUL   = 13;

  // pack-width bit positions of {pw_2,pw_4,pw_8,pw_16,pw_32}
  localparam int PW_32 = 0;
  localparam int PW_16 = 1;
  localparam int PW_8  = 2;
  localparam int PW_4  = 3;
  localparam int PW_2  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_WB_LO = 2'd2,
    ST_WB_HI = 2'd3
  } issue_state_e;

  // True when exactly one bit of the uop vector is set.
  function automatic logic uop_onehot(input logic [UOP_W-1:0] v);
    return (v != {UOP_W{1'b0}}) && ((v & (v - {{(UOP_W-1){1'b0}}, 1'b1})) == {UOP_W{1'b0}});
  endfunction

  // True when exactly one bit of the pack-width vector is set.
  function automatic logic pw_onehot(input logic [PW_W-1:0] v);
    return (v != {PW_W{1'b0}}) && ((v & (v - {{(PW_W-1){1'b0}}, 1'b1})) == {PW_W{1'b0}});
  endfunction

endpackage

// File: rtl/xc_malu_issue.sv
// ---------------------------------------------------------------------------
// xc_malu_issue
// Initiator-side sequencer for the xc_malu multi-cycle arithmetic unit.
// Accepts one decoded instruction (req_*), holds operands stable on malu_*
// while BUSY, pulses malu_flush on completion/kill/watchdog, captures the
// 64-bit result and returns it as one or two 32-bit writebacks (wb_*).
// Ports:
//   clock, resetn          clock, synchronous active-low reset
//   req_*                  instruction request handshake and fields
//   kill                   abandon any in-flight instruction
//   malu_*                 request/flush to and result/ready from xc_malu
//   wb_*                   register writeback handshake, rd and data
//   err, err_clr           sticky watchdog / illegal-uop flag and its clear
// ---------------------------------------------------------------------------
module xc_malu_issue
  import xc_malu_issue_pkg::*;
#(
  parameter int MAX_CYCLES = 64
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_rs1,
  input  logic [31:0]       req_rs2,
  input  logic [31:0]       req_rs3,
  input  logic [UOP_W-1:0]  req_uop,
  input  logic [PW_W-1:0]   req_pw,
  input  logic [4:0]        req_rd,
  input  logic              req_hi,
  input  logic              req_wide,
  input  logic              kill,
  output logic              malu_valid,
  output logic [UOP_W-1:0]  malu_uop,
  output logic [PW_W-1:0]   malu_pw,
  output logic [31:0]       malu_rs1,
  output logic [31:0]       malu_rs2,
  output logic [31:0]       malu_rs3,
  output logic              malu_flush,
  input  logic [63:0]       malu_result,
  input  logic              malu_ready,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              err,
  input  logic              err_clr
);

  localparam int CW = $clog2(MAX_CYCLES);

  issue_state_e     state_q, state_d;
  logic [UOP_W-1:0] uop_q, uop_d;
  logic [PW_W-1:0]  pw_q, pw_d;
  logic [31:0]      rs1_q, rs1_d, rs2_q, rs2_d, rs3_q, rs3_d;
  logic [4:0]       rd_q, rd_d;
  logic             hi_q, hi_d, wide_q, wide_d;
  logic [63:0]      res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             req_fire;
  logic             wd_hit;
  logic             err_set;

  assign req_fire = req_valid && req_ready;
  assign wd_hit   = (cnt_q == CW'(MAX_CYCLES - 1));

  // Handshake/flush outputs are combinational and held low during reset.
  always_comb begin
    req_ready  = resetn && (state_q == ST_IDLE) && !kill;
    malu_flush = resetn && (state_q == ST_BUSY) && (kill || malu_ready || wd_hit);
  end

  // Next-state and datapath capture for the issue FSM.
  always_comb begin
    state_d = state_q;
    uop_d   = uop_q;
    pw_d    = pw_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rs3_d   = rs3_q;
    rd_d    = rd_q;
    hi_d    = hi_q;
    wide_d  = wide_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    err_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          uop_d  = req_uop;
          pw_d   = req_pw;
          rs1_d  = req_rs1;
          rs2_d  = req_rs2;
          rs3_d  = req_rs3;
          rd_d   = req_rd;
          hi_d   = req_hi;
          wide_d = req_wide;
          cnt_d  = {CW{1'b0}};
          if (uop_onehot(req_uop) && pw_onehot(req_pw)) begin
            state_d = ST_BUSY;
          end else begin
            err_set = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // kill beats completion, completion beats the watchdog
        if (kill) begin
          state_d = ST_IDLE;
        end else if (malu_ready) begin
          res_d   = malu_result;
          state_d = ST_WB_LO;
        end else if (wd_hit) begin
          err_set = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WB_LO: begin
        if (kill) begin
          state_d = ST_IDLE;
        end else if (wb_ready) begin
          state_d = wide_q ? ST_WB_HI : ST_IDLE;
        end else begin
          state_d = ST_WB_LO;
        end
      end
      ST_WB_HI: begin
        if (kill || wb_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WB_HI;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky error: a new error event outranks a simultaneous clear.
  always_comb begin
    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      uop_q   <= {UOP_W{1'b0}};
      pw_q    <= {PW_W{1'b0}};
      rs1_q   <= 32'h0000_0000;
      rs2_q   <= 32'h0000_0000;
      rs3_q   <= 32'h0000_0000;
      rd_q    <= 5'd0;
      hi_q    <= 1'b0;
      wide_q  <= 1'b0;
      res_q   <= 64'h0000_0000_0000_0000;
      cnt_q   <= {CW{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      uop_q   <= uop_d;
      pw_q    <= pw_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rs3_q   <= rs3_d;
      rd_q    <= rd_d;
      hi_q    <= hi_d;
      wide_q  <= wide_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign malu_valid = (state_q == ST_BUSY);
  assign malu_uop   = uop_q;
  assign malu_pw    = pw_q;
  assign malu_rs1   = rs1_q;
  assign malu_rs2   = rs2_q;
  assign malu_rs3   = rs3_q;
  assign err        = err_q;
  assign wb_valid   = (state_q == ST_WB_LO) || (state_q == ST_WB_HI);

  // Writeback fields decoded purely from registers, so they stay stable while stalled.
  always_comb begin
    wb_rd   = 5'd0;
    wb_data = 32'h0000_0000;
    case (state_q)
      ST_WB_LO: begin
        wb_rd   = rd_q;
        // wide always writes the low word first, overriding hi
        wb_data = (hi_q && !wide_q) ? res_q[63:32] : res_q[31:0];
      end
      ST_WB_HI: begin
        wb_rd   = {rd_q[4:1], 1'b1};
        wb_data = res_q[63:32];
      end
      default: begin
        wb_rd   = 5'd0;
        wb_data = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: tb/tb_xc_malu_issue.sv
// ---------------------------------------------------------------------------
// tb_xc_malu_issue
// Self-checking bench for xc_malu_issue (MAX_CYCLES=8). The bench plays the
// part of xc_malu (driving malu_ready/malu_result) and of writeback.
// ---------------------------------------------------------------------------
module tb_xc_malu_issue;

  logic        clock, resetn;
  logic        req_valid, req_ready;
  logic [31:0] req_rs1, req_rs2, req_rs3;
  logic [13:0] req_uop;
  logic [4:0]  req_pw, req_rd;
  logic        req_hi, req_wide, kill;
  logic        malu_valid, malu_flush, malu_ready;
  logic [13:0] malu_uop;
  logic [4:0]  malu_pw;
  logic [31:0] malu_rs1, malu_rs2, malu_rs3;
  logic [63:0] malu_result;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err, err_clr;

  int errors = 0;
  int checks = 0;

  xc_malu_issue #(.MAX_CYCLES(8)) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3),
    .req_uop(req_uop), .req_pw(req_pw), .req_rd(req_rd),
    .req_hi(req_hi), .req_wide(req_wide), .kill(kill),
    .malu_valid(malu_valid), .malu_uop(malu_uop), .malu_pw(malu_pw),
    .malu_rs1(malu_rs1), .malu_rs2(malu_rs2), .malu_rs3(malu_rs3),
    .malu_flush(malu_flush), .malu_result(malu_result), .malu_ready(malu_ready),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .err(err), .err_clr(err_clr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [13:0] uop;
    logic [4:0]  pw;
    logic [31:0] rs1, rs2, rs3;
    logic [4:0]  rd;
    logic        hi, wide;
    int          lat;    // BUSY cycles before malu_ready
    int          stall;  // cycles wb_ready is held low per write
    logic [63:0] res;
    int          nwr;
    logic [4:0]  rd0, rd1;
    logic [31:0] d0, d1;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Present a request at the current negedge; returns in BUSY cycle 0 (+1).
  task automatic accept(input vec_t v);
    req_uop = v.uop; req_pw = v.pw; req_rs1 = v.rs1; req_rs2 = v.rs2; req_rs3 = v.rs3;
    req_rd = v.rd; req_hi = v.hi; req_wide = v.wide; req_valid = 1'b1;
    #1;
    chk("req_ready_idle", req_ready, 1'b1);
    @(negedge clock);
    req_valid = 1'b0;
    // scramble the request inputs to prove the operands were latched
    req_rs1 = 32'hDEAD_BEEF; req_rs2 = 32'h0BAD_F00D; req_uop = 14'h3FFF;
    #1;
  endtask

  task automatic run_op(input vec_t v);
    accept(v);
    for (int c = 0; c < v.lat; c++) begin
      chk("busy_valid", malu_valid, 1'b1);
      chk("busy_flush", malu_flush, 1'b0);
      chk("busy_rs1", malu_rs1, v.rs1);
      chk("busy_rs2", malu_rs2, v.rs2);
      chk("busy_uop", malu_uop, v.uop);
      @(negedge clock); #1;
    end
    malu_ready = 1'b1; malu_result = v.res; #1;
    chk("done_valid", malu_valid, 1'b1);
    chk("done_flush", malu_flush, 1'b1);
    @(negedge clock);
    malu_ready = 1'b0; malu_result = 64'h0; #1;
    chk("post_valid", malu_valid, 1'b0);
    chk("post_flush", malu_flush, 1'b0);
    for (int w = 0; w < v.nwr; w++) begin
      for (int s = 0; s < v.stall; s++) begin
        chk("stall_wb_valid", wb_valid, 1'b1);
        chk("stall_wb_rd", wb_rd, (w == 0) ? v.rd0 : v.rd1);
        chk("stall_wb_data", wb_data, (w == 0) ? v.d0 : v.d1);
        chk("stall_req_ready", req_ready, 1'b0);
        @(negedge clock); #1;
      end
      wb_ready = 1'b1; #1;
      chk("wb_valid", wb_valid, 1'b1);
      chk("wb_rd", wb_rd, (w == 0) ? v.rd0 : v.rd1);
      chk("wb_data", wb_data, (w == 0) ? v.d0 : v.d1);
      @(negedge clock);
      wb_ready = 1'b0; #1;
    end
    chk("end_wb_valid", wb_valid, 1'b0);
    chk("end_req_ready", req_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // mulu, wide, rd=4: r4 <- FFFFFFFE, r5 <- 00000001
    tbl[0] = '{uop:14'h0020, pw:5'h01, rs1:32'hFFFF_FFFF, rs2:32'h2, rs3:32'h0, rd:5'd4,
               hi:1'b0, wide:1'b1, lat:3, stall:0, res:64'h0000_0001_FFFF_FFFE,
               nwr:2, rd0:5'd4, rd1:5'd5, d0:32'hFFFF_FFFE, d1:32'h0000_0001};
    // divu 100/7, rd=9, 3 stall cycles: quotient 14
    tbl[1] = '{uop:14'h0002, pw:5'h01, rs1:32'd100, rs2:32'd7, rs3:32'h0, rd:5'd9,
               hi:1'b0, wide:1'b0, lat:5, stall:3, res:64'h0000_0002_0000_000E,
               nwr:1, rd0:5'd9, rd1:5'd0, d0:32'h0000_000E, d1:32'h0};
    // mul -1*3, hi: upper word of -3
    tbl[2] = '{uop:14'h0010, pw:5'h01, rs1:32'hFFFF_FFFF, rs2:32'd3, rs3:32'h0, rd:5'd7,
               hi:1'b1, wide:1'b0, lat:1, stall:0, res:64'hFFFF_FFFF_FFFF_FFFD,
               nwr:1, rd0:5'd7, rd1:5'd0, d0:32'hFFFF_FFFF, d1:32'h0};
    // clmul pw_8, wide overrides hi, odd rd=11 pairs with itself, ready immediately
    tbl[3] = '{uop:14'h0080, pw:5'h04, rs1:32'h1234_5678, rs2:32'h9ABC_DEF0, rs3:32'h5, rd:5'd11,
               hi:1'b1, wide:1'b1, lat:0, stall:1, res:64'hA5A5_A5A5_1234_5678,
               nwr:2, rd0:5'd11, rd1:5'd11, d0:32'h1234_5678, d1:32'hA5A5_A5A5};

    resetn = 1'b0; req_valid = 1'b0; kill = 1'b0; malu_ready = 1'b0; wb_ready = 1'b0;
    err_clr = 1'b0; malu_result = 64'h0; req_rs1 = 32'h0; req_rs2 = 32'h0; req_rs3 = 32'h0;
    req_uop = 14'h0; req_pw = 5'h0; req_rd = 5'd0; req_hi = 1'b0; req_wide = 1'b0;
    @(negedge clock); @(negedge clock); #1;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_malu_valid", malu_valid, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_flush", malu_flush, 1'b0);
    resetn = 1'b1;
    @(negedge clock); #1;

    // table-driven transactions, back to back
    for (int i = 0; i < 4; i++) run_op(tbl[i]);

    // kill two cycles into BUSY, with malu_ready also high
    accept(tbl[0]);
    @(negedge clock); @(negedge clock);
    kill = 1'b1; malu_ready = 1'b1; malu_result = 64'h1; #1;
    chk("kill_flush", malu_flush, 1'b1);
    chk("kill_req_ready", req_ready, 1'b0);
    @(negedge clock);
    kill = 1'b0; malu_ready = 1'b0; malu_result = 64'h0; #1;
    chk("kill_malu_valid", malu_valid, 1'b0);
    chk("kill_wb_valid", wb_valid, 1'b0);
    chk("kill_req_ready_after", req_ready, 1'b1);
    run_op(tbl[2]);

    // kill during WB_LO of a wide op: handshake ignored, no WB_HI
    accept(tbl[0]);
    malu_ready = 1'b1; malu_result = 64'h0000_0001_FFFF_FFFE;
    @(negedge clock);
    malu_ready = 1'b0; kill = 1'b1; wb_ready = 1'b1; #1;
    chk("killwb_wb_valid", wb_valid, 1'b1);
    @(negedge clock);
    kill = 1'b0; wb_ready = 1'b0; #1;
    chk("killwb_no_hi", wb_valid, 1'b0);
    chk("killwb_req_ready", req_ready, 1'b1);

    // watchdog: 8 BUSY cycles, flush on the 8th, then err and IDLE
    accept(tbl[1]);
    for (int c = 0; c < 8; c++) begin
      chk("wd_valid", malu_valid, 1'b1);
      chk("wd_flush", malu_flush, (c == 7) ? 1'b1 : 1'b0);
      chk("wd_err_pre", err, 1'b0);
      @(negedge clock); #1;
    end
    chk("wd_err", err, 1'b1);
    chk("wd_malu_valid", malu_valid, 1'b0);
    chk("wd_wb_valid", wb_valid, 1'b0);
    chk("wd_req_ready", req_ready, 1'b1);
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0; #1;
    chk("wd_err_clr", err, 1'b0);

    // illegal uops / pw: err set, no malu_valid; set wins over simultaneous clear
    begin
      vec_t bad;
      bad = tbl[2];
      bad.uop = 14'h0000;
      accept(bad);
      chk("ill0_err", err, 1'b1);
      chk("ill0_valid", malu_valid, 1'b0);
      err_clr = 1'b1;
      @(negedge clock); err_clr = 1'b0; #1;
      chk("ill0_clr", err, 1'b0);
      bad.uop = 14'h0011;
      err_clr = 1'b1;
      accept(bad);
      err_clr = 1'b0;
      chk("ill11_err_set_wins", err, 1'b1);
      chk("ill11_valid", malu_valid, 1'b0);
      chk("ill11_wb", wb_valid, 1'b0);
      err_clr = 1'b1;
      @(negedge clock); err_clr = 1'b0; #1;
      bad = tbl[2];
      bad.pw = 5'h03;
      accept(bad);
      chk("illpw_err", err, 1'b1);
      chk("illpw_valid", malu_valid, 1'b0);
      err_clr = 1'b1;
      @(negedge clock); err_clr = 1'b0; #1;
    end

    // reset while in WB_HI
    accept(tbl[0]);
    malu_ready = 1'b1; malu_result = 64'h0000_0001_FFFF_FFFE;
    @(negedge clock);
    malu_ready = 1'b0; wb_ready = 1'b1;
    @(negedge clock);
    wb_ready = 1'b0; #1;
    chk("rsthi_wb_valid_pre", wb_valid, 1'b1);
    chk("rsthi_wb_rd_pre", wb_rd, 5'd5);
    resetn = 1'b0; #1;
    chk("rsthi_req_ready_comb", req_ready, 1'b0);
    @(negedge clock); #1;
    chk("rsthi_wb_valid", wb_valid, 1'b0);
    chk("rsthi_malu_valid", malu_valid, 1'b0);
    chk("rsthi_req_ready", req_ready, 1'b0);
    chk("rsthi_wb_data", wb_data, 32'h0);
    resetn = 1'b1;
    @(negedge clock); #1;
    chk("rsthi_idle_after", req_ready, 1'b1);
    run_op(tbl[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
